// File: rtl/text_wr_pkg.sv
// Shared codes, FSM states and width helper for the text cursor writer.
// TEXT_WR_CR_EN (see text_cursor_writer) selects whether CR_CODE is decoded.
package text_wr_pkg;

    localparam logic [7:0] DEL_CODE = 8'h7F;
    localparam logic [7:0] CR_CODE  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        WR
    } state_t;

    // Counter width for n positions, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Registered falling-edge detector for slow debounced inputs.
// o_fall is high in the first cycle the input reads 0 after reading 1.
module strobe_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_fall
);

    logic r_sig;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_sig <= 1'b0;
        else       r_sig <= i_sig;
    end

    assign o_fall = r_sig & ~i_sig;

endmodule

// File: rtl/text_cursor_writer.sv
// Character-entry controller: strobe-driven cursor tracking with deferred text-buffer writes.
// Optional macro TEXT_WR_CR_EN: when defined, CR_CODE moves to the next line without writing.
module text_cursor_writer
    import text_wr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_strobe,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_wr_allow,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_W-1:0]     o_din,
    output logic                  o_we,
    output logic [cw(COLS)-1:0]   o_col,
    output logic [cw(ROWS)-1:0]   o_row,
    output logic                  o_busy,
    output logic                  o_drop
);

    localparam int COL_W = cw(COLS);
    localparam int ROW_W = cw(ROWS);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

    if (COLS * ROWS > (1 << ADDR_W)) begin : g_geom_check
        $error("text_cursor_writer: COLS*ROWS exceeds 2**ADDR_W");
    end

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   lin_q, lin_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                drop_q, drop_d;
    logic                fall;
    logic                is_del;
    logic                is_cr;

    strobe_edge u_strobe_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_strobe),
        .o_fall (fall)
    );

    assign is_del = (i_data == DATA_W'(DEL_CODE));
`ifdef TEXT_WR_CR_EN
    assign is_cr  = (i_data == DATA_W'(CR_CODE));
`else
    assign is_cr  = 1'b0;
`endif

    // lin tracks row*COLS+col incrementally so no multiplier is needed
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        lin_d   = lin_q;
        addr_d  = addr_q;
        din_d   = din_q;
        drop_d  = fall && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (is_del) begin
                        if (col_q != '0) begin
                            col_d = col_q - COL_ONE;
                            lin_d = lin_q - ADDR_ONE;
                        end else if (row_q != '0) begin
                            col_d = COL_LAST;
                            row_d = row_q - ROW_ONE;
                            lin_d = lin_q - ADDR_ONE;
                        end
                        addr_d  = lin_d;
                        din_d   = '0;
                        state_d = PEND;
                    end else if (is_cr) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            lin_d = '0;
                        end else begin
                            row_d = row_q + ROW_ONE;
                            lin_d = lin_q - ADDR_W'(col_q) + ROW_STEP;
                        end
                    end else begin
                        addr_d  = lin_q;
                        din_d   = i_data;
                        state_d = PEND;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d = '0;
                                lin_d = '0;
                            end else begin
                                row_d = row_q + ROW_ONE;
                                lin_d = lin_q + ADDR_ONE;
                            end
                        end else begin
                            col_d = col_q + COL_ONE;
                            lin_d = lin_q + ADDR_ONE;
                        end
                    end
                end
            end
            PEND:    if (i_wr_allow) state_d = WR;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lin_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lin_q   <= lin_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            drop_q  <= drop_d;
        end
    end

    assign o_addr = addr_q;
    assign o_din  = din_q;
    assign o_we   = (state_q == WR);
    assign o_busy = (state_q != IDLE);
    assign o_col  = col_q;
    assign o_row  = row_q;
    assign o_drop = drop_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench for text_cursor_writer using a linear-position reference model.
module tb_text_cursor_writer;

    localparam int DATA_W = 8;
    localparam int COLS   = 7;
    localparam int ROWS   = 5;
    localparam int ADDR_W = 6;
    localparam int NPOS   = COLS * ROWS;
    localparam int CW     = text_wr_pkg::cw(COLS);
    localparam int RW     = text_wr_pkg::cw(ROWS);

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_strobe = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_wr_allow = 1'b0;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_din;
    logic              o_we;
    logic [CW-1:0]     o_col;
    logic [RW-1:0]     o_row;
    logic              o_busy;
    logic              o_drop;

    text_cursor_writer #(
        .DATA_W (DATA_W),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_strobe   (i_strobe),
        .i_data     (i_data),
        .i_wr_allow (i_wr_allow),
        .o_addr     (o_addr),
        .o_din      (o_din),
        .o_we       (o_we),
        .o_col      (o_col),
        .o_row      (o_row),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  pos = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: cursor is one linear position 0..NPOS-1.
    task automatic model_apply(input logic [7:0] code, output bit wr);
        bit cr;
        wr_t w;
`ifdef TEXT_WR_CR_EN
        cr = (code == 8'h0D);
`else
        cr = 1'b0;
`endif
        wr = 1'b1;
        if (code == 8'h7F) begin
            if (pos > 0) pos--;
            w.addr = pos; w.data = 0;
            exp_q.push_back(w);
        end else if (cr) begin
            pos = ((pos / COLS + 1) % ROWS) * COLS;
            wr = 1'b0;
        end else begin
            w.addr = pos; w.data = int'(code);
            exp_q.push_back(w);
            pos = (pos + 1) % NPOS;
        end
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_col"}, int'(o_col), pos % COLS);
        chk({tag, "_row"}, int'(o_row), pos / COLS);
    endtask

    // Leaves the bench in cycle N+1 (sampled 1 time unit after the edge).
    task automatic issue(input logic [7:0] code);
        bit wr;
        model_apply(code, wr);
        i_data   = code;
        i_strobe = 1'b1;
        @(posedge clk); #1;
        i_strobe = 1'b0;
        @(posedge clk); #1;
        check_cursor("cursor");
        chk("busy_after_edge", int'(o_busy), int'(wr));
    endtask

    task automatic drain(input int pct);
        int n;
        n = 0;
        while (o_busy && n < 300) begin
            i_wr_allow = ($urandom_range(1, 100) <= pct);
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", int'(o_busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, int'(o_addr), 0);
        chk({tag, "_din"},  int'(o_din),  0);
        chk({tag, "_we"},   int'(o_we),   0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_drop"}, int'(o_drop), 0);
        chk({tag, "_col"},  int'(o_col),  0);
        chk({tag, "_row"},  int'(o_row),  0);
    endtask

    function automatic logic [7:0] printable();
        return 8'($urandom_range(32, 126));
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!i_rst && o_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", int'(o_addr), w.addr);
                chk("wr_data", int'(o_din), w.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        int r;

        // Reset
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check_reset_outputs("reset");

        // First write: exact latency with write window always open
        i_wr_allow = 1'b1;
        issue(8'h41);
        chk("first_we_n1", int'(o_we), 0);
        chk("first_addr", int'(o_addr), 0);
        chk("first_din", int'(o_din), 8'h41);
        @(posedge clk); #1;
        chk("first_we_n2", int'(o_we), 1);
        @(posedge clk); #1;
        chk("first_busy_n3", int'(o_busy), 0);

        // DEL from (1,0) then DEL at (0,0)
        issue(8'h7F); drain(100);
        issue(8'h7F); drain(100);

        // Move to (0,1), DEL wraps back to (COLS-1,0)
        for (int i = 0; i < COLS; i++) begin
            issue(printable()); drain(70);
        end
        issue(8'h7F); drain(100);

        // Walk to the last cell and write there; address must hold while pending
        while (pos != NPOS - 1) begin
            issue(printable()); drain(60);
        end
        i_wr_allow = 1'b0;
        code = printable();
        issue(code);
        for (int i = 0; i < 5; i++) begin
            chk("last_addr_hold", int'(o_addr), NPOS - 1);
            chk("last_din_hold", int'(o_din), int'(code));
            @(posedge clk); #1;
        end
        drain(100);

        // Carriage return at (5,3)
        while (pos != 3 * COLS + 5) begin
            issue(printable()); drain(80);
        end
        issue(8'h0D);
        drain(100);

        // Write window held closed; second edge is dropped
        i_wr_allow = 1'b0;
        issue(printable());
        for (int i = 0; i < 10; i++) begin
            chk("hold_busy", int'(o_busy), 1);
            chk("hold_we", int'(o_we), 0);
            @(posedge clk); #1;
        end
        i_data = 8'h7F;
        i_strobe = 1'b1;
        @(posedge clk); #1;
        i_strobe = 1'b0;
        @(posedge clk); #1;
        chk("drop_pulse", int'(o_drop), 1);
        check_cursor("drop_cursor");
        @(posedge clk); #1;
        chk("drop_one_cycle", int'(o_drop), 0);
        for (int i = 0; i < 36; i++) begin
            chk("hold2_busy", int'(o_busy), 1);
            chk("hold2_we", int'(o_we), 0);
            @(posedge clk); #1;
        end
        drain(100);
        chk("hold_release_queue", exp_q.size(), 0);

        // Randomized command mix with random write windows
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      code = 8'h7F;
            else if (r < 30) code = 8'h0D;
            else             code = printable();
            issue(code);
            drain($urandom_range(25, 100));
        end

        // Reset while a write is pending cancels it
        i_wr_allow = 1'b0;
        issue(printable());
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_pend");
        void'(exp_q.pop_back());
        pos = 0;
        i_rst = 1'b0;
        i_wr_allow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_we", int'(o_we), 0);
            @(posedge clk); #1;
        end
        issue(8'h42);
        drain(100);

        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Character-entry controller between the debounced keypad/button input and the VGA text-buffer write port. It samples a parallel character code on each falling edge of a strobe and tracks a 2-D cursor with wrap-around. Delete steps back and clears; carriage return starts a new line. Each resulting buffer write is deferred until the display signals a safe write window. This block generalises the ad-hoc capture logic in the top level to arbitrary code width and screen geometry.

## Interface
Parameters:
- DATA_W, 8, character code width
- COLS, 80, text columns per row
- ROWS, 30, text rows; COLS*ROWS must be at most 2^ADDR_W (elaboration error otherwise)
- ADDR_W, 12, text-buffer address width

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock (global-buffered pixel clock)
- i_rst  in  1  synchronous active-high reset
- i_strobe  in  1  debounced entry strobe; command taken on falling edge
- i_data  in  DATA_W  character code, sampled in the edge cycle
- i_wr_allow  in  1  1 = buffer write permitted this cycle (outside sync pulse)
- o_addr  out  ADDR_W  write address, linear row*COLS+col
- o_din  out  DATA_W  write data
- o_we  out  1  one-cycle write enable
- o_col  out  clog2(COLS)  cursor column
- o_row  out  clog2(ROWS)  cursor row
- o_busy  out  1  write pending (state PEND or WR)
- o_drop  out  1  one-cycle pulse: edge arrived while busy, command discarded

## Operation
- Edge detect: r_strobe holds the previous i_strobe. An edge is i_strobe=0 with r_strobe=1.
- Command decode in the edge cycle, IDLE only:
  - Printable (not DEL_CODE, not CR_CODE): write i_data at the cursor. Then advance: col+1; at col=COLS-1 go to col 0, row+1; at row=ROWS-1 go to row 0.
  - DEL_CODE (7F): retreat: col-1; at col 0 go to col COLS-1, row-1. At (0,0) the cursor stays. Write 0 at the new cursor position. At (0,0) the write goes to address 0.
  - CR_CODE (0D): col=0, row+1 with wrap. No write; stays IDLE.
- Linear address is kept incrementally alongside col/row; no multiplier. Wrap to (0,0) resets it to 0.
- FSM:
  - IDLE: on write command, latch o_addr/o_din and go to PEND.
  - PEND: if i_wr_allow=1, go to WR.
  - WR: o_we=1 for this cycle only, then IDLE.
- Edge in PEND or WR: command ignored, cursor unchanged, o_drop=1 in the next cycle.
- Reset values: state IDLE, col=row=0, address 0, o_addr=0, o_din=0, o_we=0, o_busy=0, o_drop=0, r_strobe=0. A reset mid-PEND or mid-WR cancels the write; no o_we after reset.

## Timing
- Edge seen in cycle N:
  - Cursor, o_addr and o_din are updated at cycle N+1; o_busy=1 from N+1.
  - If i_wr_allow=1 at N+1, o_we=1 at N+2 and o_busy=0 at N+3.
  - Each later cycle with i_wr_allow=0 delays o_we by one cycle; no timeout.
- o_addr and o_din are stable from PEND entry through the WR cycle.
- o_col/o_row show the post-command cursor from N+1. CR latency is also one cycle.
- Maximum command rate is one per 3 cycles; the debounced strobe is far slower.

## Configuration
- TEXT_WR_CR_EN defined: CR_CODE is handled as above.
- TEXT_WR_CR_EN undefined: CR_CODE is treated as printable; no CR decode logic is built.

## Structure
- Package text_wr_pkg holds:
  - DEL_CODE (8'h7F) and CR_CODE (8'h0D)
  - state enum (IDLE, PEND, WR)
  - clog2-based width helper for o_col/o_row
- Sub-module strobe_edge: registered falling-edge detector, reusable by other debounced inputs.
- The cursor and address update stays inline in text_cursor_writer.

## Test plan
- Reset, then strobe with i_data=8'h41 and i_wr_allow=1 → o_we at N+2, o_addr=0, o_din=8'h41; then col=1, row=0.
- Cursor at (COLS-1, ROWS-1), printable entered → write to address COLS*ROWS-1; cursor becomes (0,0), o_addr stays until WR.
- Cursor at (0,1), DEL entered → cursor (COLS-1,0), write 0 to address COLS-1. DEL at (0,0) → cursor (0,0), write 0 to address 0.
- i_wr_allow held 0 for 50 cycles after an edge → o_busy=1 throughout, no o_we. Second edge in that window → o_drop pulse, cursor unchanged. Releasing i_wr_allow → exactly one o_we.
- With TEXT_WR_CR_EN, cursor (5,3), CR entered → cursor (0,4), no o_we. Without TEXT_WR_CR_EN → write 8'h0D at 3*COLS+5.
- Assert i_rst during PEND → no o_we, all outputs at reset values next cycle.
